// File: rtl/scope_pkg.sv
// scope_pkg: command bytes, FSM state encoding and trig_cfg field offsets
// shared by the scope command sequencer and its tx holding register.
package scope_pkg;

  localparam logic [7:0] CMD_ARM   = 8'h41;  // 'A'
  localparam logic [7:0] CMD_RISE  = 8'h52;  // 'R'
  localparam logic [7:0] CMD_FALL  = 8'h46;  // 'F'
  localparam logic [7:0] CMD_ABORT = 8'h58;  // 'X'
  localparam logic [7:0] CMD_STAT  = 8'h53;  // 'S'

  localparam int LEVEL_LSB = 0;
  localparam int LEVEL_W   = 40;
  localparam int POST_LSB  = 40;
  localparam int POST_W    = 40;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PAYLOAD = 3'd1,
    ST_APPLY   = 3'd2,
    ST_ARMED   = 3'd3,
    ST_REPORT  = 3'd4
  } state_e;

  // Status query reply: bit1 = waiting for capture, bit0 = capture done level.
  function automatic logic [7:0] status_byte(input logic armed, input logic done);
    return {6'b0, armed, done};
  endfunction

endpackage

// File: rtl/scope_tx_hold.sv
// scope_tx_hold: single-entry valid/ready holding register for the status byte.
// A load overrides the slot; the owner only loads when the slot is empty.
module scope_tx_hold
  import scope_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data
);

  logic       valid_q, valid_d;
  logic [7:0] data_q, data_d;

  // Hold the byte until the transmitter accepts it.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (valid_q && tx_ready) valid_d = 1'b0;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end
  end

  // Holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign tx_valid = valid_q;
  assign tx_data  = data_q;

endmodule

// File: rtl/scope_cmd_ctrl.sv
// scope_cmd_ctrl: byte-command sequencer between the UART and the scope datapath.
// Optional feature macro: SCOPE_STATUS_EN enables the 'S' status query.
//
//  state   | meaning
//  --------+--------------------------------------------------------------
//  IDLE    | waiting for a command byte
//  PAYLOAD | shifting in trigger payload bytes, timeout watchdog running
//  APPLY   | one cycle: shadow copied to trig_cfg, cfg_update follows
//  ARMED   | capture armed, waiting for scope_done or 'X'
//  REPORT  | DONE_BYTE held on tx until accepted
module scope_cmd_ctrl
  import scope_pkg::*;
#(
  parameter int         PAYLOAD_BYTES = 10,
  parameter int         TIMEOUT_CYC   = 1_000_000,
  parameter logic [7:0] DONE_BYTE     = 8'h44
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rx_valid,
  input  logic [7:0]                 rx_data,
  output logic                       tx_valid,
  output logic [7:0]                 tx_data,
  input  logic                       tx_ready,
  output logic [8*PAYLOAD_BYTES-1:0] trig_cfg,
  output logic                       trig_rising,
  output logic                       cfg_update,
  output logic                       scope_arm,
  output logic                       scope_abort,
  input  logic                       scope_done,
  output logic                       busy
);

  localparam int CFG_W = 8 * PAYLOAD_BYTES;
  localparam int CNT_W = $clog2(PAYLOAD_BYTES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAYLOAD_BYTES - 1);
  localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TIMEOUT_CYC - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] pay_cnt_q, pay_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [CFG_W-1:0] shadow_q, shadow_d;
  logic [CFG_W-1:0] trig_cfg_q, trig_cfg_d;
  logic             rising_lat_q, rising_lat_d;
  logic             trig_rising_q, trig_rising_d;
  logic             cfg_update_q, cfg_update_d;
  logic             scope_arm_q, scope_arm_d;
  logic             scope_abort_q, scope_abort_d;
  logic             tx_load;
  logic [7:0]       tx_load_data;

  // Next-state, payload capture, watchdog and strobe decode.
  always_comb begin
    state_d       = state_q;
    pay_cnt_d     = pay_cnt_q;
    to_cnt_d      = to_cnt_q;
    shadow_d      = shadow_q;
    trig_cfg_d    = trig_cfg_q;
    rising_lat_d  = rising_lat_q;
    trig_rising_d = trig_rising_q;
    cfg_update_d  = 1'b0;
    scope_arm_d   = 1'b0;
    scope_abort_d = 1'b0;
    tx_load       = 1'b0;
    tx_load_data  = DONE_BYTE;
    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          if (rx_data == CMD_RISE || rx_data == CMD_FALL) begin
            rising_lat_d = (rx_data == CMD_RISE);
            state_d      = ST_PAYLOAD;
            pay_cnt_d    = '0;
            to_cnt_d     = TO_LOAD;
            shadow_d     = '0;
          end else if (rx_data == CMD_ARM) begin
            scope_arm_d = 1'b1;
            state_d     = ST_ARMED;
          end
`ifdef SCOPE_STATUS_EN
          else if (rx_data == CMD_STAT && !tx_valid) begin
            tx_load      = 1'b1;
            tx_load_data = status_byte(1'b0, scope_done);
          end
`endif
        end
      end
      ST_PAYLOAD: begin
        if (rx_valid) begin
          // LSB-first: after the last byte, byte k sits at [8k+7:8k].
          shadow_d = {rx_data, shadow_q[CFG_W-1:8]};
          to_cnt_d = TO_LOAD;
          if (pay_cnt_q == CNT_LAST) begin
            pay_cnt_d = '0;
            state_d   = ST_APPLY;
          end else begin
            pay_cnt_d = pay_cnt_q + CNT_W'(1);
          end
        end else if (to_cnt_q == '0) begin
          pay_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q - TO_W'(1);
        end
      end
      ST_APPLY: begin
        trig_cfg_d    = shadow_q;
        trig_rising_d = rising_lat_q;
        cfg_update_d  = 1'b1;
        state_d       = ST_IDLE;
      end
      ST_ARMED: begin
        // scope_arm_q is high only on the first ARMED cycle, so a done level
        // present at entry is ignored until the arm strobe has gone out.
        if (rx_valid && rx_data == CMD_ABORT) begin
          scope_abort_d = 1'b1;
          state_d       = ST_IDLE;
        end
`ifdef SCOPE_STATUS_EN
        else if (rx_valid && rx_data == CMD_STAT && !tx_valid) begin
          tx_load      = 1'b1;
          tx_load_data = status_byte(1'b1, scope_done);
        end
`endif
        else if (scope_done && !scope_arm_q && !tx_valid) begin
          tx_load      = 1'b1;
          tx_load_data = DONE_BYTE;
          state_d      = ST_REPORT;
        end
      end
      ST_REPORT: begin
        if (tx_valid && tx_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pay_cnt_q     <= '0;
      to_cnt_q      <= '0;
      shadow_q      <= '0;
      trig_cfg_q    <= '0;
      rising_lat_q  <= 1'b1;
      trig_rising_q <= 1'b1;
      cfg_update_q  <= 1'b0;
      scope_arm_q   <= 1'b0;
      scope_abort_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pay_cnt_q     <= pay_cnt_d;
      to_cnt_q      <= to_cnt_d;
      shadow_q      <= shadow_d;
      trig_cfg_q    <= trig_cfg_d;
      rising_lat_q  <= rising_lat_d;
      trig_rising_q <= trig_rising_d;
      cfg_update_q  <= cfg_update_d;
      scope_arm_q   <= scope_arm_d;
      scope_abort_q <= scope_abort_d;
    end
  end

  scope_tx_hold u_tx_hold (
    .clk       (clk),
    .rst       (rst),
    .load      (tx_load),
    .load_data (tx_load_data),
    .tx_ready  (tx_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data)
  );

  assign trig_cfg    = trig_cfg_q;
  assign trig_rising = trig_rising_q;
  assign cfg_update  = cfg_update_q;
  assign scope_arm   = scope_arm_q;
  assign scope_abort = scope_abort_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_scope_cmd_ctrl.sv
// Directed bench for scope_cmd_ctrl (TIMEOUT_CYC shortened to 50).
module tb_scope_cmd_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic [79:0] trig_cfg;
  logic        trig_rising;
  logic        cfg_update;
  logic        scope_arm;
  logic        scope_abort;
  logic        scope_done = 1'b0;
  logic        busy;

  int n_checks = 0;
  int n_err    = 0;
  int cfg_cnt = 0, arm_cnt = 0, abort_cnt = 0, overlap_cnt = 0;
  int exp_arm = 3, exp_abort = 1;

  scope_cmd_ctrl #(.PAYLOAD_BYTES(10), .TIMEOUT_CYC(50), .DONE_BYTE(8'h44)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .trig_cfg    (trig_cfg),
    .trig_rising (trig_rising),
    .cfg_update  (cfg_update),
    .scope_arm   (scope_arm),
    .scope_abort (scope_abort),
    .scope_done  (scope_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cfg_update)  cfg_cnt++;
    if (scope_arm)   arm_cnt++;
    if (scope_abort) abort_cnt++;
    if (int'(cfg_update) + int'(scope_arm) + int'(scope_abort) > 1) overlap_cnt++;
  end

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one byte for exactly one clock; returns 1ns after the sampling edge.
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1 rx_valid = 1'b1;
    rx_data = b;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step(3);
    rst = 1'b0;
    step(1);
    check("rst_cfg", trig_cfg, 80'h0);
    check("rst_rising", trig_rising, 1);
    check("rst_busy", busy, 0);
    check("rst_txv", tx_valid, 0);
    check("rst_strobes", {cfg_update, scope_arm, scope_abort}, 0);

    // reset in the middle of a payload
    send_byte(8'h52);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    check("t1_busy_pre", busy, 1);
    rst = 1'b1;
    #2;
    check("t1_busy_async", busy, 0);
    step(1);
    rst = 1'b0;
    send_byte(8'h11);
    step(3);
    check("t1_busy_post", busy, 0);
    check("t1_cfg", trig_cfg, 80'h0);
    check("t1_cfgcnt", cfg_cnt, 0);

    // falling trigger, byte order
    send_byte(8'h46);
    for (int i = 1; i <= 10; i++) send_byte(8'(i));
    check("f_apply_noupd", cfg_update, 0);
    check("f_apply_busy", busy, 1);
    step(1);
    check("f_upd", cfg_update, 1);
    check("f_cfg", trig_cfg, 80'h0A09_0807_0605_0403_0201);
    check("f_rising", trig_rising, 0);
    step(1);
    check("f_upd_off", cfg_update, 0);
    check("f_idle", busy, 0);

    // rising trigger, 2-clock latency
    send_byte(8'h52);
    for (int i = 0; i < 8; i++) send_byte(8'h00);
    send_byte(8'h40);
    send_byte(8'h00);
    check("t2_lat1", cfg_update, 0);
    step(1);
    check("t2_upd", cfg_update, 1);
    check("t2_cfg", trig_cfg, 80'h0040_0000_0000_0000_0000);
    check("t2_rising", trig_rising, 1);
    step(1);
    check("t2_upd_off", cfg_update, 0);

    // arm, ignored bytes, done, stalled tx
    send_byte(8'h41);
    check("t3_arm", scope_arm, 1);
    check("t3_busy", busy, 1);
    step(1);
    check("t3_arm_off", scope_arm, 0);
    send_byte(8'h52);
    send_byte(8'h41);
    step(95);
    check("t3_wait_txv", tx_valid, 0);
    check("t3_wait_busy", busy, 1);
    check("t3_ign_arm", arm_cnt, 1);
    scope_done = 1'b1;
    step(1);
    check("t3_txv", tx_valid, 1);
    check("t3_txd", tx_data, 8'h44);
    scope_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("t3_hold_v", tx_valid, 1);
      check("t3_hold_d", tx_data, 8'h44);
    end
    tx_ready = 1'b1;
    step(1);
    tx_ready = 1'b0;
    check("t3_txv_off", tx_valid, 0);
    check("t3_idle", busy, 0);

    // done already high when armed: honoured on the 2nd ARMED cycle
    scope_done = 1'b1;
    send_byte(8'h41);
    check("e_first_txv", tx_valid, 0);
    step(1);
    check("e_second_txv", tx_valid, 0);
    step(1);
    check("e_third_txv", tx_valid, 1);
    scope_done = 1'b0;
    tx_ready = 1'b1;
    step(1);
    tx_ready = 1'b0;
    check("e_idle", busy, 0);

    // payload timeout
    send_byte(8'h46);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
    step(49);
    check("t4_before_to", busy, 1);
    step(1);
    check("t4_after_to", busy, 0);
    check("t4_cfg", trig_cfg, 80'h0040_0000_0000_0000_0000);
    check("t4_rising", trig_rising, 1);
    check("t4_cfgcnt", cfg_cnt, 2);
    send_byte(8'h41);
    check("t4_arm", scope_arm, 1);

    // abort beats done in the same cycle
    step(1);
    @(posedge clk);
    #1 rx_valid = 1'b1;
    rx_data = 8'h58;
    scope_done = 1'b1;
    step(1);
    rx_valid = 1'b0;
    check("t5_abort", scope_abort, 1);
    check("t5_idle", busy, 0);
    check("t5_txv", tx_valid, 0);
    step(1);
    scope_done = 1'b0;
    check("t5_abort_off", scope_abort, 0);
    check("t5_txv2", tx_valid, 0);

    // status query
    send_byte(8'h53);
`ifdef SCOPE_STATUS_EN
    check("t6_idle_txv", tx_valid, 1);
    check("t6_idle_txd", tx_data, 8'h00);
    check("t6_idle_busy", busy, 0);
    tx_ready = 1'b1;
    step(1);
    tx_ready = 1'b0;
    send_byte(8'h41);
    step(1);
    send_byte(8'h53);
    check("t6_arm_txv", tx_valid, 1);
    check("t6_arm_txd", tx_data, 8'h02);
    check("t6_arm_busy", busy, 1);
    tx_ready = 1'b1;
    step(1);
    tx_ready = 1'b0;
    send_byte(8'h58);
    exp_arm = 4;
    exp_abort = 2;
`else
    step(3);
    check("t6_s_txv", tx_valid, 0);
    check("t6_s_busy", busy, 0);
`endif
    step(2);
    check("cnt_arm", arm_cnt, exp_arm);
    check("cnt_abort", abort_cnt, exp_abort);
    check("cnt_cfg", cfg_cnt, 2);
    check("overlap", overlap_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
